// File: rtl/round_robin_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// The arbiter connects through the slave modport; requesters use master.
interface round_robin_arbiter_if #(
    parameter int N = 2
) ();
    localparam int ID_W = $clog2(N);

    logic [N-1:0]    request;
    logic [N-1:0]    grant;
    logic [ID_W-1:0] grant_id;
    logic            busy;

    modport master (
        output request,
        input  grant,
        input  grant_id,
        input  busy
    );

    modport slave (
        input  request,
        output grant,
        output grant_id,
        output busy
    );
endinterface

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with optional hold limit; every output comes straight
// from flops, so there is no combinational path from request to grant.
module round_robin_arbiter #(
    parameter int N        = 2,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    round_robin_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(N);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] g, g_nxt;
    logic [ID_W-1:0] last, last_nxt;
    logic [7:0]      hold_cnt, hold_nxt;
    logic [N-1:0]    grant_q, grant_nxt;
    logic [ID_W-1:0] grant_id_q, grant_id_nxt;
    logic            busy_q, busy_nxt;

    logic            fnd_idle, fnd_other;
    logic [ID_W-1:0] idx_idle, idx_other;
    logic            hold_expired;

    // First set request in cyclic order from start, optionally skipping excl.
    // Returns {found, index}.
    function automatic logic [ID_W:0] rr_search(
        input logic [N-1:0]    req,
        input logic [ID_W-1:0] start,
        input logic            excl_en,
        input logic [ID_W-1:0] excl
    );
        logic            found;
        logic [ID_W-1:0] pick;
        logic [ID_W-1:0] idx;
        found = 1'b0;
        pick  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = ID_W'((32'(start) + k) % N);
            if (!found && req[idx] && !(excl_en && idx == excl)) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        return {found, pick};
    endfunction

    function automatic logic [ID_W-1:0] next_of(input logic [ID_W-1:0] x);
        return ID_W'((32'(x) + 32'd1) % N);
    endfunction

    always_comb begin
        {fnd_idle, idx_idle}   = rr_search(bus.request, next_of(last), 1'b0, '0);
        {fnd_other, idx_other} = rr_search(bus.request, next_of(g), 1'b1, g);
    end

    assign hold_expired = (MAX_HOLD != 0) && (hold_cnt >= 8'(MAX_HOLD));

    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        last_nxt  = last;
        hold_nxt  = hold_cnt;
        case (state)
            IDLE: begin
                if (fnd_idle) begin
                    state_nxt = GRANT;
                    g_nxt     = idx_idle;
                    last_nxt  = idx_idle;
                    hold_nxt  = 8'd1;
                end
            end
            GRANT: begin
                if (!bus.request[g]) begin
                    if (fnd_other) begin
                        g_nxt    = idx_other;
                        last_nxt = idx_other;
                        hold_nxt = 8'd1;
                    end else begin
                        state_nxt = IDLE;
                        hold_nxt  = '0;
                    end
                end else if (hold_expired) begin
                    // Expired owner keeps the grant (counter frozen) until someone else asks.
                    if (fnd_other) begin
                        g_nxt    = idx_other;
                        last_nxt = idx_other;
                        hold_nxt = 8'd1;
                    end
                end else if (hold_cnt != 8'hFF) begin
                    hold_nxt = hold_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant_nxt    = '0;
        grant_id_nxt = '0;
        busy_nxt     = 1'b0;
        if (state_nxt == GRANT) begin
            grant_nxt    = N'(1) << g_nxt;
            grant_id_nxt = g_nxt;
            busy_nxt     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            g          <= '0;
            last       <= ID_W'(N - 1);
            hold_cnt   <= '0;
            grant_q    <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            g          <= g_nxt;
            last       <= last_nxt;
            hold_cnt   <= hold_nxt;
            grant_q    <= grant_nxt;
            grant_id_q <= grant_id_nxt;
            busy_q     <= busy_nxt;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.grant_id = grant_id_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed bench for round_robin_arbiter: N=4 with MAX_HOLD=4 and MAX_HOLD=0.
module tb_round_robin_arbiter;
    logic clk;
    logic rst;
    int   pass_cnt;
    int   check_cnt;

    round_robin_arbiter_if #(.N(4)) bus  ();
    round_robin_arbiter_if #(.N(4)) bus0 ();

    round_robin_arbiter #(.N(4), .MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    round_robin_arbiter #(.N(4), .MAX_HOLD(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.request  = 4'b0000;
        bus0.request = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_cnt++;
            if ({bus.grant, bus.grant_id, bus.busy} !== 7'b0000_00_0)
                $display("FAIL reset[%0d]: got grant=%b id=%0d busy=%b want 0000/0/0",
                         i, bus.grant, bus.grant_id, bus.busy);
            else pass_cnt++;
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        bus.request = 4'b0001;
        tick();
        check_cnt++;
        if ({bus.grant, bus.grant_id, bus.busy} !== 7'b0001_00_1)
            $display("FAIL single_grant: got grant=%b id=%0d busy=%b want 0001/0/1",
                     bus.grant, bus.grant_id, bus.busy);
        else pass_cnt++;
        bus.request = 4'b0000;
        tick();
        check_cnt++;
        if ({bus.grant, bus.grant_id, bus.busy} !== 7'b0000_00_0)
            $display("FAIL single_release: got grant=%b id=%0d busy=%b want 0000/0/0",
                     bus.grant, bus.grant_id, bus.busy);
        else pass_cnt++;
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g;
        logic [1:0] exp_id;
        do_reset();
        bus.request = 4'b1111;
        for (int c = 0; c < 17; c++) begin
            tick();
            exp_id = 2'((c / 4) % 4);
            exp_g  = 4'b0001 << exp_id;
            check_cnt++;
            if ({bus.grant, bus.grant_id, bus.busy} !== {exp_g, exp_id, 1'b1})
                $display("FAIL rotation[%0d]: got grant=%b id=%0d busy=%b want %b/%0d/1",
                         c, bus.grant, bus.grant_id, bus.busy, exp_g, exp_id);
            else pass_cnt++;
        end
        bus.request = 4'b0000;
    endtask

    task automatic test_release();
        do_reset();
        bus.request = 4'b0010;
        tick();
        bus.request = 4'b1111;
        tick();
        check_cnt++;
        if ({bus.grant, bus.grant_id} !== 6'b0010_01)
            $display("FAIL release_owner1: got grant=%b id=%0d want 0010/1",
                     bus.grant, bus.grant_id);
        else pass_cnt++;
        bus.request = 4'b1101;
        tick();
        check_cnt++;
        if ({bus.grant, bus.grant_id, bus.busy} !== 7'b0100_10_1)
            $display("FAIL release_handover: got grant=%b id=%0d busy=%b want 0100/2/1",
                     bus.grant, bus.grant_id, bus.busy);
        else pass_cnt++;
        // release and new request on the same cycle: gapless handover
        do_reset();
        bus.request = 4'b0001;
        tick();
        bus.request = 4'b0010;
        tick();
        check_cnt++;
        if ({bus.grant, bus.grant_id, bus.busy} !== 7'b0010_01_1)
            $display("FAIL simultaneous_release: got grant=%b id=%0d busy=%b want 0010/1/1",
                     bus.grant, bus.grant_id, bus.busy);
        else pass_cnt++;
        bus.request = 4'b0000;
    endtask

    task automatic test_wrap();
        do_reset();
        bus.request = 4'b1000;
        tick();
        bus.request = 4'b1101;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_cnt++;
            if ({bus.grant, bus.grant_id} !== 6'b1000_11)
                $display("FAIL wrap_hold[%0d]: got grant=%b id=%0d want 1000/3",
                         i, bus.grant, bus.grant_id);
            else pass_cnt++;
        end
        tick();
        check_cnt++;
        if ({bus.grant, bus.grant_id, bus.busy} !== 7'b0001_00_1)
            $display("FAIL wrap_preempt: got grant=%b id=%0d busy=%b want 0001/0/1",
                     bus.grant, bus.grant_id, bus.busy);
        else pass_cnt++;
        do_reset();
        bus.request = 4'b1000;
        tick();
        bus.request = 4'b0101;
        tick();
        check_cnt++;
        if ({bus.grant, bus.grant_id} !== 6'b0001_00)
            $display("FAIL wrap_release: got grant=%b id=%0d want 0001/0",
                     bus.grant, bus.grant_id);
        else pass_cnt++;
        bus.request = 4'b0000;
    endtask

    task automatic test_hold_limit();
        int bad;
        do_reset();
        bus.request  = 4'b0001;
        bus0.request = 4'b0011;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_cnt++;
            if ({bus.grant, bus.grant_id} !== 6'b0001_00) begin
                $display("FAIL lone_hold[%0d]: got grant=%b id=%0d want 0001/0",
                         i, bus.grant, bus.grant_id);
                bad++;
            end else pass_cnt++;
            check_cnt++;
            if ({bus0.grant, bus0.grant_id} !== 6'b0001_00)
                $display("FAIL unlimited_hold[%0d]: got grant=%b id=%0d want 0001/0",
                         i, bus0.grant, bus0.grant_id);
            else pass_cnt++;
        end
        // expired owner is re-evaluated as soon as a competitor appears
        bus.request  = 4'b0011;
        bus0.request = 4'b0010;
        tick();
        check_cnt++;
        if ({bus.grant, bus.grant_id} !== 6'b0010_01)
            $display("FAIL expired_preempt: got grant=%b id=%0d want 0010/1",
                     bus.grant, bus.grant_id);
        else pass_cnt++;
        check_cnt++;
        if ({bus0.grant, bus0.grant_id, bus0.busy} !== 7'b0010_01_1)
            $display("FAIL unlimited_release: got grant=%b id=%0d busy=%b want 0010/1/1",
                     bus0.grant, bus0.grant_id, bus0.busy);
        else pass_cnt++;
        bus.request  = 4'b0000;
        bus0.request = 4'b0000;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.request = 4'b1111;
        for (int i = 0; i < 9; i++) tick();
        check_cnt++;
        if ({bus.grant, bus.grant_id} !== 6'b0100_10)
            $display("FAIL mid_owner2: got grant=%b id=%0d want 0100/2",
                     bus.grant, bus.grant_id);
        else pass_cnt++;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_cnt++;
            if ({bus.grant, bus.grant_id, bus.busy} !== 7'b0000_00_0)
                $display("FAIL mid_reset[%0d]: got grant=%b id=%0d busy=%b want 0000/0/0",
                         i, bus.grant, bus.grant_id, bus.busy);
            else pass_cnt++;
        end
        rst = 1'b0;
        tick();
        check_cnt++;
        if ({bus.grant, bus.grant_id, bus.busy} !== 7'b0001_00_1)
            $display("FAIL post_reset_first: got grant=%b id=%0d busy=%b want 0001/0/1",
                     bus.grant, bus.grant_id, bus.busy);
        else pass_cnt++;
        bus.request = 4'b0000;
    endtask

    initial begin
        pass_cnt     = 0;
        check_cnt    = 0;
        rst          = 1'b1;
        bus.request  = 4'b0000;
        bus0.request = 4'b0000;
        test_reset();
        test_single();
        test_rotation();
        test_release();
        test_wrap();
        test_hold_limit();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule

// File: doc/round_robin_arbiter.md
ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 Parameter N, default 2: number of requesters; legal range 2..32.
REQ-002 Parameter MAX_HOLD, default 4: maximum consecutive grant cycles per owner while others wait; 0 = unlimited; legal range 0..255.
REQ-003 Localparam ID_W = $clog2(N): width of grant_id.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-006 request  input  N  bit i high = requester i wants the resource; level-sensitive, held until served.
REQ-007 grant  output  N  registered one-hot grant; all-zero when no owner.
REQ-008 grant_id  output  ID_W  registered binary index of current owner; 0 when no owner.
REQ-009 busy  output  1  registered; high whenever grant is nonzero.

Function
REQ-010 Internal state: owner-valid flag (IDLE/GRANT), owner index g, hold counter hold_cnt (8 bits), last-owner register last.
REQ-011 Round-robin search: from start index s, pick the first i in cyclic order s, s+1, ..., N-1, 0, ..., s-1 with request[i]=1, optionally excluding one index.
REQ-012 IDLE, any request bit high: next edge enters GRANT with g = search from (last+1) mod N, hold_cnt=1, last=g.
REQ-013 IDLE, request all zero: stay IDLE; grant=0, grant_id=0, busy=0.
REQ-014 GRANT, request[g]=0: release; search from (g+1) mod N excluding g; if found, next edge grants it with hold_cnt=1, last updated; else next edge enters IDLE.
REQ-015 GRANT, request[g]=1, MAX_HOLD=0 or hold_cnt<MAX_HOLD: keep g; hold_cnt increments, saturating at 255.
REQ-016 GRANT, request[g]=1, MAX_HOLD>0, hold_cnt>=MAX_HOLD, another request pending: next edge grants search from (g+1) mod N excluding g, hold_cnt=1.
REQ-017 GRANT, request[g]=1, hold_cnt>=MAX_HOLD, no other request: keep g; hold_cnt stays at MAX_HOLD; re-evaluated every cycle.
REQ-018 Latency: request visible before edge k produces grant after edge k; no combinational path from request to any output.
REQ-019 Handover is gapless: a release or preemption with a pending requester moves grant directly to the new owner with no all-zero cycle.
REQ-020 grant is always zero or one-hot; grant_id always equals the index of the set grant bit; busy == |grant.
REQ-021 Wrap-around: search from N-1 continues at 0; owner N-1 preempted hands to lowest pending index.
REQ-022 Simultaneous release and new requests are resolved in the same edge per REQ-014; requests arriving on the owner's release cycle are eligible.

Reset
REQ-023 rst=1 at a posedge: next state IDLE, grant=0, grant_id=0, busy=0, hold_cnt=0, last=N-1 (so the first search starts at index 0).
REQ-024 rst takes priority over all other conditions, including mid-grant; request is ignored while rst=1.

Verification (N=4, MAX_HOLD=4 unless stated)
REQ-025 rst high 2 cycles, request=0000 -> grant=0000, grant_id=0, busy=0 on every cycle.
REQ-026 After reset, drive request=0001 at edge k -> after edge k+1 grant=0001, grant_id=0, busy=1; drop request -> one edge later grant=0000, busy=0.
REQ-027 request=1111 held from IDLE -> grant 0001 for 4 cycles, then 0010 x4, 0100 x4, 1000 x4, then 0001; no gap cycles.
REQ-028 Owner 1 (grant=0010), request changes 1111->1101 -> next edge grant=0100, grant_id=2.
REQ-029 Only request=0001 held 20 cycles -> grant stays 0001 throughout; MAX_HOLD=0 build with request=0011 -> grant stays 0001 until bit 0 drops, then 0010.
REQ-030 rst asserted while grant=0100 -> next edge grant=0000; rst released with request=1111 -> first grant 0001.
